// File: rtl/fifo_read_arbiter_if.sv
// fifo_read_arbiter_if: groups the two FIFO read ports and the outgoing
// valid/ready word stream of fifo_read_arbiter into one bundle.
// master = arbiter side, slave = FIFOs plus downstream consumer.
interface fifo_read_arbiter_if #(
    parameter int WIDTH = 8
);
    // Channel-0 FIFO read port
    logic             ch0_empty_i;
    logic             ch0_rd_en_o;
    logic [WIDTH-1:0] ch0_data_i;

    // Channel-1 FIFO read port
    logic             ch1_empty_i;
    logic             ch1_rd_en_o;
    logic [WIDTH-1:0] ch1_data_i;

    // Output word stream
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] out_data_o;
    logic             out_ch_o;
    logic             out_last_o;

    // Status
    logic             busy_o;

    modport master (
        input  ch0_empty_i, ch0_data_i,
        input  ch1_empty_i, ch1_data_i,
        input  out_ready_i,
        output ch0_rd_en_o, ch1_rd_en_o,
        output out_valid_o, out_data_o, out_ch_o, out_last_o,
        output busy_o
    );

    modport slave (
        output ch0_empty_i, ch0_data_i,
        output ch1_empty_i, ch1_data_i,
        output out_ready_i,
        input  ch0_rd_en_o, ch1_rd_en_o,
        input  out_valid_o, out_data_o, out_ch_o, out_last_o,
        input  busy_o
    );
endinterface

// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter: drains two sample FIFOs into one valid/ready stream.
// Each grant reads up to BURST_LEN words from one channel; every word goes
// through READ (strobe) -> LATCH (capture registered FIFO data) -> SEND
// (hold until accepted). A burst ends early when the channel runs empty.
// Optional build macro: ARB_CH0_PRIORITY_EN selects fixed ch0 priority
// instead of the default round-robin grant.
module fifo_read_arbiter #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo_read_arbiter_if.master  bus
);

    localparam int                CNT_W    = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        LATCH = 2'd2,
        SEND  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_grant;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_ch;
    logic             r_out_last;

    logic             w_ch0_avail;
    logic             w_ch1_avail;
    logic             w_any_avail;
    logic             w_grant_sel;
    logic             w_sel_empty;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_handshake;
    logic             w_ch0_rd_en;
    logic             w_ch1_rd_en;
    logic             w_out_valid;
    logic             w_busy;

    assign w_ch0_avail = ~bus.ch0_empty_i;
    assign w_ch1_avail = ~bus.ch1_empty_i;
    assign w_any_avail = w_ch0_avail | w_ch1_avail;
    assign w_handshake = (r_state == SEND) && bus.out_ready_i;

    // Read port of the currently granted channel
    assign w_sel_empty = r_grant ? bus.ch1_empty_i : bus.ch0_empty_i;
    assign w_sel_data  = r_grant ? bus.ch1_data_i  : bus.ch0_data_i;

`ifdef ARB_CH0_PRIORITY_EN
    // Fixed priority: ch0 whenever it has data, ch1 only when ch0 is empty
    assign w_grant_sel = ~w_ch0_avail;
`else
    logic r_last_grant;

    // Round-robin grant choice: on contention pick the channel not served last
    always_comb begin
        // NOTE: every signal written in an always_comb gets a default first so
        // no path through the block leaves it unassigned and infers a latch.
        w_grant_sel = 1'b0;
        if (w_ch0_avail && w_ch1_avail) begin
            w_grant_sel = ~r_last_grant;
        end else if (w_ch1_avail) begin
            w_grant_sel = 1'b1;
        end
    end

    // Remember which channel finished the last burst; ch0 wins first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_handshake && r_out_last) begin
            r_last_grant <= r_grant;
        end
    end
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values, independent of block ordering.
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and per-state strobes
    always_comb begin
        w_state_nxt = r_state;
        w_ch0_rd_en = 1'b0;
        w_ch1_rd_en = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (w_any_avail) begin
                    w_state_nxt = READ;
                end
            end
            READ: begin
                // Exactly one strobe, to a channel already seen non-empty
                w_ch0_rd_en = ~r_grant;
                w_ch1_rd_en =  r_grant;
                w_state_nxt = LATCH;
            end
            LATCH: begin
                w_state_nxt = SEND;
            end
            SEND: begin
                w_out_valid = 1'b1;
                if (bus.out_ready_i) begin
                    w_state_nxt = r_out_last ? IDLE : READ;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Grant and burst counter: chosen in IDLE, counted once per latched word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant <= 1'b0;
            r_count <= '0;
        end else if ((r_state == IDLE) && w_any_avail) begin
            r_grant <= w_grant_sel;
            r_count <= '0;
        end else if (r_state == LATCH) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Output word register: loaded in LATCH, held through SEND until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the data register is reset too, because its value is visible
        // on out_data_o straight out of reset and an in-flight word must vanish.
        if (!rst_n) begin
            r_out_data <= '0;
            r_out_ch   <= 1'b0;
            r_out_last <= 1'b0;
        end else if (r_state == LATCH) begin
            r_out_data <= w_sel_data;
            r_out_ch   <= r_grant;
            r_out_last <= (r_count == LAST_CNT) || w_sel_empty;
        end
    end

    assign bus.ch0_rd_en_o = w_ch0_rd_en;
    assign bus.ch1_rd_en_o = w_ch1_rd_en;
    assign bus.out_valid_o = w_out_valid;
    assign bus.out_data_o  = r_out_data;
    assign bus.out_ch_o    = r_out_ch;
    assign bus.out_last_o  = r_out_last;
    assign bus.busy_o      = w_busy;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// tb_fifo_read_arbiter: directed bench for fifo_read_arbiter with a queue
// model of both FIFOs and a scoreboard of expected output words.
// Build with ARB_CH0_PRIORITY_EN defined to exercise fixed priority.
module tb_fifo_read_arbiter;

    localparam int WIDTH     = 8;
    localparam int BURST_LEN = 4;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             ch;
        logic             last;
    } word_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Free-running cycle index for latency measurements
    always @(posedge clk) cyc <= cyc + 1;

    fifo_read_arbiter_if #(.WIDTH(WIDTH)) bus ();

    fifo_read_arbiter #(
        .WIDTH     (WIDTH),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- FIFO model (registered read data) ----------------
    logic [WIDTH-1:0] fq0[$];
    logic [WIDTH-1:0] fq1[$];
    logic [WIDTH-1:0] ld0[8];
    logic [WIDTH-1:0] ld1[8];
    int               ld0_n;
    int               ld1_n;
    logic             ld_req;
    logic             flush_req;

    // Pop on strobe, append loaded words, then publish the empty flags
    always @(posedge clk) begin
        if (flush_req) begin
            fq0.delete();
            fq1.delete();
        end
        if (bus.ch0_rd_en_o && fq0.size() > 0) bus.ch0_data_i <= fq0.pop_front();
        if (bus.ch1_rd_en_o && fq1.size() > 0) bus.ch1_data_i <= fq1.pop_front();
        if (ld_req) begin
            for (int i = 0; i < ld0_n; i++) fq0.push_back(ld0[i]);
            for (int i = 0; i < ld1_n; i++) fq1.push_back(ld1[i]);
        end
        bus.ch0_empty_i <= (fq0.size() == 0);
        bus.ch1_empty_i <= (fq1.size() == 0);
    end

    // ---------------- scoreboard and bookkeeping ----------------
    word_t sb[$];
    int    acc_cyc[$];
    int    rd0_cyc[$];
    int    rd1_n;
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] d, input logic c, input logic l);
        word_t w;
        w.data = d;
        w.ch   = c;
        w.last = l;
        sb.push_back(w);
    endtask

    task automatic load(input int n0, input logic [WIDTH-1:0] base0, input logic [WIDTH-1:0] step0,
                        input int n1, input logic [WIDTH-1:0] base1, input logic [WIDTH-1:0] step1);
        for (int i = 0; i < 8; i++) begin
            ld0[i] = base0 + WIDTH'(i) * step0;
            ld1[i] = base1 + WIDTH'(i) * step1;
        end
        ld0_n  = n0;
        ld1_n  = n1;
        ld_req = 1'b1;
        @(posedge clk);
        #1 ld_req = 1'b0;
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        flush_req        = 1'b1;
        bus.out_ready_i  = 1'b1;
        sb.delete();
        acc_cyc.delete();
        rd0_cyc.delete();
        rd1_n = 0;
        repeat (2) @(posedge clk);
        #1 flush_req = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Watch the bus for up to budget cycles, comparing accepted words with the
    // scoreboard; returns at the negedge where the n-th handshake is visible.
    task automatic run_expect(input int n, input int budget);
        int    seen;
        word_t w;
        seen = 0;
        for (int k = 0; k < budget && seen < n; k++) begin
            @(negedge clk);
            check("rd_exclusive", bus.ch0_rd_en_o & bus.ch1_rd_en_o, 32'd0);
            if (bus.ch0_rd_en_o) begin
                rd0_cyc.push_back(cyc);
                check("rd0_nonempty", bus.ch0_empty_i, 32'd0);
            end
            if (bus.ch1_rd_en_o) begin
                rd1_n++;
                check("rd1_nonempty", bus.ch1_empty_i, 32'd0);
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                check("sb_has_entry", sb.size() > 0, 32'd1);
                w = (sb.size() > 0) ? sb.pop_front() : '0;
                check("out_data", bus.out_data_o, w.data);
                check("out_ch",   bus.out_ch_o,   w.ch);
                check("out_last", bus.out_last_o, w.last);
                acc_cyc.push_back(cyc);
                seen++;
            end
        end
        check("word_count", seen, n);
    endtask

    // Hard stop in case a wait is ever left unbounded
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ready_cyc;
        ld_req          = 1'b0;
        flush_req       = 1'b0;
        ld0_n           = 0;
        ld1_n           = 0;
        bus.out_ready_i = 1'b1;

        // ---- asynchronous reset values ----
        rst_n = 1'b0;
        #1;
        check("rst_valid", bus.out_valid_o, 32'd0);
        check("rst_busy",  bus.busy_o,      32'd0);
        check("rst_data",  bus.out_data_o,  32'd0);
        check("rst_rd",    {bus.ch0_rd_en_o, bus.ch1_rd_en_o}, 32'd0);
        check("rst_chlast", {bus.out_ch_o, bus.out_last_o}, 32'd0);

        // ---- single channel, early end on empty ----
        do_reset();
        load(3, 8'h11, 8'h11, 0, 8'h00, 8'h00);
        push_exp(8'h11, 1'b0, 1'b0);
        push_exp(8'h22, 1'b0, 1'b0);
        push_exp(8'h33, 1'b0, 1'b1);
        run_expect(3, 60);
        check("t1_rd0_count", rd0_cyc.size(), 32'd3);
        check("t1_rd0_gap0",  rd0_cyc[1] - rd0_cyc[0], 32'd3);
        check("t1_rd0_gap1",  rd0_cyc[2] - rd0_cyc[1], 32'd3);
        check("t1_rd1_never", rd1_n, 32'd0);
        @(negedge clk);
        check("t1_idle_busy",  bus.busy_o,      32'd0);
        check("t1_idle_valid", bus.out_valid_o, 32'd0);

        // ---- both channels full: burst order and spacing ----
        do_reset();
        load(8, 8'hA0, 8'h01, 8, 8'hB0, 8'h01);
`ifdef ARB_CH0_PRIORITY_EN
        for (int i = 0; i < 8; i++) push_exp(8'hA0 + WIDTH'(i), 1'b0, (i % 4) == 3);
        for (int i = 0; i < 8; i++) push_exp(8'hB0 + WIDTH'(i), 1'b1, (i % 4) == 3);
`else
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) push_exp(8'hA0 + WIDTH'(4 * b + i), 1'b0, i == 3);
            for (int i = 0; i < 4; i++) push_exp(8'hB0 + WIDTH'(4 * b + i), 1'b1, i == 3);
        end
`endif
        run_expect(16, 300);
        check("t2_in_burst_gap",  acc_cyc[1] - acc_cyc[0], 32'd3);
        check("t2_burst_end_gap", acc_cyc[4] - acc_cyc[3], 32'd4);

        // ---- idle-to-output latency on ch1, then a 5-cycle stall ----
        do_reset();
        bus.out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        load(0, 8'h00, 8'h00, 2, 8'h5A, 8'h01);
        @(negedge clk);
        check("t3_c0_rd1",   bus.ch1_rd_en_o, 32'd0);
        check("t3_c0_busy",  bus.busy_o,      32'd0);
        @(negedge clk);
        check("t3_c1_rd",    {bus.ch0_rd_en_o, bus.ch1_rd_en_o}, 32'd1);
        check("t3_c1_busy",  bus.busy_o,      32'd1);
        @(negedge clk);
        check("t3_c2_rd1",   bus.ch1_rd_en_o, 32'd0);
        check("t3_c2_valid", bus.out_valid_o, 32'd0);
        @(negedge clk);
        check("t3_c3_valid", bus.out_valid_o, 32'd1);
        check("t3_c3_data",  bus.out_data_o,  32'h5A);
        check("t3_c3_chlast", {bus.out_ch_o, bus.out_last_o}, 32'd2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t4_stall_valid",  bus.out_valid_o, 32'd1);
            check("t4_stall_data",   bus.out_data_o,  32'h5A);
            check("t4_stall_chlast", {bus.out_ch_o, bus.out_last_o}, 32'd2);
            check("t4_stall_rd",     {bus.ch0_rd_en_o, bus.ch1_rd_en_o}, 32'd0);
        end
        @(posedge clk);
        #1 bus.out_ready_i = 1'b1;
        ready_cyc = cyc;
        push_exp(8'h5A, 1'b1, 1'b0);
        push_exp(8'h5B, 1'b1, 1'b1);
        run_expect(2, 40);
        check("t4_accept_on_ready", acc_cyc[0], ready_cyc);

        // ---- reset mid-SEND, then ch0 wins again ----
        do_reset();
        load(1, 8'hC0, 8'h00, 2, 8'hD0, 8'h01);
        push_exp(8'hC0, 1'b0, 1'b1);
        run_expect(1, 40);
        @(posedge clk);
        #1 bus.out_ready_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.out_valid_o) break;
        end
        check("t5_pre_valid", bus.out_valid_o, 32'd1);
        check("t5_pre_data",  bus.out_data_o,  32'hD0);
        check("t5_pre_ch",    bus.out_ch_o,    32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", bus.out_valid_o, 32'd0);
        check("t5_rst_data",  bus.out_data_o,  32'd0);
        check("t5_rst_busy",  bus.busy_o,      32'd0);
        check("t5_rst_chlast", {bus.out_ch_o, bus.out_last_o}, 32'd0);
        load(1, 8'hC1, 8'h00, 0, 8'h00, 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready_i = 1'b1;
        push_exp(8'hC1, 1'b0, 1'b1);
        push_exp(8'hD1, 1'b1, 1'b1);
        run_expect(2, 40);
        check("t5_sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
